// File: rtl/conv_output_drain_if.sv
// Accumulator-side handshake and packed output bus of the conv output drain.
// The drain connects through the slave modport; the producer/sink side uses master.
interface conv_output_drain_if #(
    parameter int unsigned IO_DATA_WIDTH      = 16,
    parameter int unsigned ACCUMULATION_WIDTH = 32,
    parameter int unsigned FEATURE_MAP_WIDTH  = 64,
    parameter int unsigned FEATURE_MAP_HEIGHT = 64,
    parameter int unsigned OUTPUT_NB_CHANNELS = 32
);
    localparam int unsigned XW = $clog2(FEATURE_MAP_WIDTH);
    localparam int unsigned YW = $clog2(FEATURE_MAP_HEIGHT);
    localparam int unsigned CW = $clog2(OUTPUT_NB_CHANNELS);

    logic                          start;
    logic                          acc_valid;
    logic                          acc_ready;
    logic [ACCUMULATION_WIDTH-1:0] acc_data;
    logic                          out_ready;
    logic                          output_valid;
    logic [IO_DATA_WIDTH-1:0]      con_1;
    logic [IO_DATA_WIDTH-1:0]      con_2;
    logic [IO_DATA_WIDTH-1:0]      con_3;
    logic [XW-1:0]                 output_x;
    logic [YW-1:0]                 output_y;
    logic [CW-1:0]                 output_ch;
    logic                          driving_cons;
    logic                          frame_done;

    modport master (
        output start, acc_valid, acc_data, out_ready,
        input  acc_ready, output_valid, con_1, con_2, con_3,
        input  output_x, output_y, output_ch, driving_cons, frame_done
    );

    modport slave (
        input  start, acc_valid, acc_data, out_ready,
        output acc_ready, output_valid, con_1, con_2, con_3,
        output output_x, output_y, output_ch, driving_cons, frame_done
    );
endinterface

// File: rtl/conv_output_drain.sv
// Quantises accumulated conv results, packs three channels per beat and streams the
// beats through a small fall-through FIFO onto the con bus, owning bus turnaround.
module conv_output_drain #(
    parameter int unsigned IO_DATA_WIDTH      = 16,
    parameter int unsigned ACCUMULATION_WIDTH = 32,
    parameter int unsigned FEATURE_MAP_WIDTH  = 64,
    parameter int unsigned FEATURE_MAP_HEIGHT = 64,
    parameter int unsigned OUTPUT_NB_CHANNELS = 32,
    parameter int unsigned OUT_SHIFT          = 8,
    parameter int unsigned FIFO_DEPTH         = 4
) (
    input logic                clk,
    input logic                arst_n_in,
    conv_output_drain_if.slave drain_io
);
    localparam int unsigned AW = ACCUMULATION_WIDTH;
    localparam int unsigned IW = IO_DATA_WIDTH;
    localparam int unsigned XW = $clog2(FEATURE_MAP_WIDTH);
    localparam int unsigned YW = $clog2(FEATURE_MAP_HEIGHT);
    localparam int unsigned CW = $clog2(OUTPUT_NB_CHANNELS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = 3 * IW + XW + YW + CW;

    localparam logic signed [AW:0] QRnd =
        (OUT_SHIFT > 0) ? ((AW + 1)'(1) << (OUT_SHIFT - 1)) : '0;
    localparam logic signed [AW:0] QMax = (AW + 1)'((64'(1) << (IW - 1)) - 64'(1));
    localparam logic signed [AW:0] QMin = ~QMax;

    typedef enum logic [1:0] {StIdle, StTurnOn, StStream, StTurnOff} state_e;

    state_e         state_q, state_d;
    logic [1:0]     lane_q, lane_d;
    logic [IW-1:0]  l1_q, l1_d, l2_q, l2_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           in_done_q, in_done_d;
    logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]    cnt_q, cnt_d;
    logic [EW-1:0]  mem_q [FIFO_DEPTH];

    logic signed [AW:0] q_sum, q_shift;
    logic [IW-1:0]  q_val;
    logic           stream, fifo_full, out_valid, pop, push, acc_rdy, acc_fire;
    logic           pix_end, beat_done;
    logic [IW-1:0]  push_c1, push_c2, push_c3;
    logic [EW-1:0]  push_entry, rd_entry;

    // Round half up, arithmetic shift, then clamp to the lane range.
    always_comb begin
        q_sum   = $signed({drain_io.acc_data[AW-1], drain_io.acc_data}) + QRnd;
        q_shift = q_sum >>> OUT_SHIFT;
        if (q_shift > QMax) begin
            q_val = QMax[IW-1:0];
        end else if (q_shift < QMin) begin
            q_val = QMin[IW-1:0];
        end else begin
            q_val = q_shift[IW-1:0];
        end
    end

    always_comb begin
        stream    = (state_q == StStream);
        fifo_full = (cnt_q == (PW + 1)'(FIFO_DEPTH));
        out_valid = stream && (cnt_q != '0);
        pop       = out_valid && drain_io.out_ready;
        pix_end   = (32'(ch_q) + 32'(lane_q)) == 32'(OUTPUT_NB_CHANNELS - 1);
        beat_done = (lane_q == 2'd2) || pix_end;
        // A completing word needs a FIFO slot now; earlier lanes only need the pack register.
        acc_rdy   = stream && !in_done_q && (!beat_done || !fifo_full || pop);
        acc_fire  = drain_io.acc_valid && acc_rdy;
        push      = acc_fire && beat_done;
        push_c1   = (lane_q == 2'd0) ? q_val : l1_q;
        push_c2   = (lane_q == 2'd1) ? q_val : ((lane_q == 2'd2) ? l2_q : '0);
        push_c3   = (lane_q == 2'd2) ? q_val : '0;
        push_entry = {push_c1, push_c2, push_c3, x_q, y_q, ch_q};
        wptr_d    = wptr_q + PW'(push);
        rptr_d    = rptr_q + PW'(pop);
        cnt_d     = cnt_q + (PW + 1)'(push) - (PW + 1)'(pop);
    end

    always_comb begin
        lane_d    = lane_q;
        l1_d      = l1_q;
        l2_d      = l2_q;
        ch_d      = ch_q;
        x_d       = x_q;
        y_d       = y_q;
        in_done_d = in_done_q;
        if ((state_q == StIdle) && drain_io.start) begin
            lane_d    = '0;
            ch_d      = '0;
            x_d       = '0;
            y_d       = '0;
            in_done_d = 1'b0;
        end else if (acc_fire) begin
            if (beat_done) begin
                lane_d = '0;
                if (pix_end) begin
                    ch_d = '0;
                    if (x_q == XW'(FEATURE_MAP_WIDTH - 1)) begin
                        x_d = '0;
                        if (y_q == YW'(FEATURE_MAP_HEIGHT - 1)) begin
                            y_d       = '0;
                            in_done_d = 1'b1;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end else begin
                    ch_d = ch_q + CW'(3);
                end
            end else begin
                lane_d = lane_q + 2'd1;
                if (lane_q == 2'd0) begin
                    l1_d = q_val;
                end else begin
                    l2_d = q_val;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (drain_io.start) state_d = StTurnOn;
            StTurnOn:  state_d = StStream;
            // Only the final beat can be left once the input side is done.
            StStream:  if (pop && in_done_q && (cnt_q == (PW + 1)'(1))) state_d = StTurnOff;
            StTurnOff: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state_q   <= StIdle;
            lane_q    <= '0;
            l1_q      <= '0;
            l2_q      <= '0;
            ch_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            in_done_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            l1_q      <= l1_d;
            l2_q      <= l2_d;
            ch_q      <= ch_d;
            x_q       <= x_d;
            y_q       <= y_d;
            in_done_q <= in_done_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= push_entry;
        end
    end

    assign rd_entry = mem_q[rptr_q];

    always_comb begin
        drain_io.acc_ready    = acc_rdy;
        drain_io.output_valid = out_valid;
        {drain_io.con_1, drain_io.con_2, drain_io.con_3,
         drain_io.output_x, drain_io.output_y, drain_io.output_ch} = out_valid ? rd_entry : '0;
        drain_io.driving_cons = (state_q == StTurnOn) || (state_q == StStream);
        drain_io.frame_done   = (state_q == StTurnOff);
    end
endmodule
